// File: rtl/sp_ram_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
package sp_ram_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/sp_ram_arb_starve.sv
// Counts consecutive denied M1 cycles; starve_o forces M1 to win the next arbitration.
module sp_ram_arb_starve
  import sp_ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic starve_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (m1_req && !m1_gnt) begin
      if (cnt != CW'(STARVE_MAX)) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign starve_o = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-master front end for a single-port data RAM: fixed priority to M0,
// with a starvation guard that periodically hands the port to M1.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  owner_e winner;
  owner_e resp_owner;
  logic   resp_is_rd;
  logic   starve;

  sp_ram_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .m1_req   (m1_req_i),
    .m1_gnt   (m1_gnt_o),
    .starve_o (starve)
  );

  always_comb begin
    winner = OWN_NONE;
    if (m1_req_i && (starve || !m0_req_i)) winner = OWN_M1;
    else if (m0_req_i)                     winner = OWN_M0;
  end

  assign m0_gnt_o = (winner == OWN_M0);
  assign m1_gnt_o = (winner == OWN_M1);
  assign ram_en_o = m0_gnt_o | m1_gnt_o;

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    case (winner)
      OWN_M0: begin
        ram_addr_o  = m0_addr_i;
        ram_we_o    = m0_we_i;
        ram_be_o    = m0_be_i;
        ram_wdata_o = m0_wdata_i;
      end
      OWN_M1: begin
        ram_addr_o  = m1_addr_i;
        ram_we_o    = m1_we_i;
        ram_be_o    = m1_be_i;
        ram_wdata_o = m1_wdata_i;
      end
      default: ;
    endcase
  end

  // Response tracking is refreshed every cycle so back-to-back accesses pipeline.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_owner <= OWN_NONE;
      resp_is_rd <= 1'b0;
    end else begin
      resp_owner <= winner;
      resp_is_rd <= ~ram_we_o;
    end
  end

  assign m0_rvalid_o = (resp_owner == OWN_M0);
  assign m1_rvalid_o = (resp_owner == OWN_M1);
  assign m0_rdata_o  = (m0_rvalid_o && resp_is_rd) ? ram_rdata_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o && resp_is_rd) ? ram_rdata_i : '0;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rstn_i)
    !(m0_gnt_o && m1_gnt_o));
  a_en_has_req: assert property (@(posedge clk) disable iff (!rstn_i)
    ram_en_o |-> ((m0_gnt_o && m0_req_i) || (m1_gnt_o && m1_req_i)));
  a_m0_rv: assert property (@(posedge clk) disable iff (!rstn_i)
    m0_gnt_o |=> m0_rvalid_o);
  a_m0_norv: assert property (@(posedge clk) disable iff (!rstn_i)
    !m0_gnt_o |=> !m0_rvalid_o);
  a_m1_rv: assert property (@(posedge clk) disable iff (!rstn_i)
    m1_gnt_o |=> m1_rvalid_o);
  a_m1_norv: assert property (@(posedge clk) disable iff (!rstn_i)
    !m1_gnt_o |=> !m1_rvalid_o);
`endif

endmodule
